// File: rtl/spi_burst_ctrl.sv
// Buffered front end for spi_master: queues slave-tagged TX bytes, issues them one
// at a time over the tx valid/ready handshake and captures each MISO byte into an RX FIFO.
module spi_burst_ctrl #(
  parameter int FIFO_DEPTH      = 8,
  parameter int RX_TIMEOUT_CLKS = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tx_push,
  input  logic [2:0]                  i_tx_slave,
  input  logic [7:0]                  i_tx_byte,
  output logic                        o_tx_full,
  output logic [$clog2(FIFO_DEPTH):0] o_tx_level,
  input  logic                        i_rx_pop,
  output logic                        o_rx_empty,
  output logic [2:0]                  o_rx_slave,
  output logic [7:0]                  o_rx_byte,
  output logic                        o_busy,
  output logic                        o_tx_overflow,
  output logic                        o_rx_underflow,
  output logic                        o_timeout_err,
  input  logic                        i_clear_err,
  output logic                        o_m_tx_data_valid,
  output logic [2:0]                  o_m_slave_select,
  output logic [7:0]                  o_m_tx_data_byte,
  input  logic                        i_m_tx_ready,
  input  logic                        i_m_rx_data_valid,
  input  logic [7:0]                  i_m_rx_data_byte
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RX_TIMEOUT_CLKS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX} state_t;

  state_t        state_q;
  logic [CW-1:0] tmo_cnt_q;
  logic          m_valid_q;
  logic [2:0]    m_slave_q;
  logic [7:0]    m_byte_q;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW:0] tx_cnt, rx_cnt;
  logic [10:0] tx_mem_q [FIFO_DEPTH];
  logic [10:0] rx_mem_q [FIFO_DEPTH];
  logic [10:0] tx_head, rx_head;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_wr, tx_rd, rx_wr, rx_rd, tmo_ev;
  logic ovf_q, ovf_d, udf_q, udf_d, tmo_q, tmo_d;

  assign tx_cnt   = tx_wptr_q - tx_rptr_q;
  assign rx_cnt   = rx_wptr_q - rx_rptr_q;
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == (AW+1)'(FIFO_DEPTH));
  assign rx_full  = (rx_cnt == (AW+1)'(FIFO_DEPTH));
  assign tx_head  = tx_mem_q[tx_rptr_q[AW-1:0]];
  assign rx_head  = rx_mem_q[rx_rptr_q[AW-1:0]];

  // RX space is reserved before issuing, so the single outstanding byte always fits.
  assign tx_wr  = i_tx_push & ~tx_full;
  assign tx_rd  = (state_q == IDLE) & ~tx_empty & ~rx_full & i_m_tx_ready;
  assign rx_wr  = (state_q == WAIT_RX) & i_m_rx_data_valid;
  assign rx_rd  = i_rx_pop & ~rx_empty;
  assign tmo_ev = (state_q == WAIT_RX) & ~i_m_rx_data_valid &
                  (tmo_cnt_q == CW'(RX_TIMEOUT_CLKS - 1));

  always_comb begin
    tx_wptr_d = tx_wptr_q + (AW+1)'(tx_wr);
    tx_rptr_d = tx_rptr_q + (AW+1)'(tx_rd);
    rx_wptr_d = rx_wptr_q + (AW+1)'(rx_wr);
    rx_rptr_d = rx_rptr_q + (AW+1)'(rx_rd);
    ovf_d     = (ovf_q & ~i_clear_err) | (i_tx_push & tx_full);
    udf_d     = (udf_q & ~i_clear_err) | (i_rx_pop & rx_empty);
    tmo_d     = (tmo_q & ~i_clear_err) | tmo_ev;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      tmo_q     <= tmo_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (tx_wr) tx_mem_q[tx_wptr_q[AW-1:0]] <= {i_tx_slave, i_tx_byte};
    if (rx_wr) rx_mem_q[rx_wptr_q[AW-1:0]] <= {m_slave_q, i_m_rx_data_byte};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_slave_q <= 3'd0;
      m_byte_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_rd) begin
            m_valid_q <= 1'b1;
            m_slave_q <= tx_head[10:8];
            m_byte_q  <= tx_head[7:0];
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          m_valid_q <= 1'b0;
          tmo_cnt_q <= '0;
          state_q   <= WAIT_RX;
        end
        WAIT_RX: begin
          if (i_m_rx_data_valid || tmo_ev) state_q <= IDLE;
          else tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_full         = tx_full;
  assign o_tx_level        = tx_cnt;
  assign o_rx_empty        = rx_empty;
  assign o_rx_slave        = rx_head[10:8];
  assign o_rx_byte         = rx_head[7:0];
  assign o_busy            = (state_q != IDLE) | ~tx_empty;
  assign o_tx_overflow     = ovf_q;
  assign o_rx_underflow    = udf_q;
  assign o_timeout_err     = tmo_q;
  assign o_m_tx_data_valid = m_valid_q;
  assign o_m_slave_select  = m_slave_q;
  assign o_m_tx_data_byte  = m_byte_q;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: queue-based reference model checked every cycle, a simple
// echoing spi_master stand-in, and directed scenarios with literal expectations.
module tb_spi_burst_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_push = 1'b0, rx_pop = 1'b0, clr = 1'b0;
  logic [2:0] tx_slave = 3'd0;
  logic [7:0] tx_byte = 8'd0;
  logic       m_ready, m_rxv;
  logic [7:0] m_rxb;
  logic       tx_full, rx_empty, busy, ovf, udf, tmo_err, m_valid;
  logic [2:0] rx_slave, m_slave;
  logic [7:0] rx_byte, m_byte;
  logic [$clog2(DEPTH):0] tx_level;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.FIFO_DEPTH(DEPTH), .RX_TIMEOUT_CLKS(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_tx_push(tx_push), .i_tx_slave(tx_slave), .i_tx_byte(tx_byte),
    .o_tx_full(tx_full), .o_tx_level(tx_level),
    .i_rx_pop(rx_pop), .o_rx_empty(rx_empty), .o_rx_slave(rx_slave), .o_rx_byte(rx_byte),
    .o_busy(busy), .o_tx_overflow(ovf), .o_rx_underflow(udf), .o_timeout_err(tmo_err),
    .i_clear_err(clr),
    .o_m_tx_data_valid(m_valid), .o_m_slave_select(m_slave), .o_m_tx_data_byte(m_byte),
    .i_m_tx_ready(m_ready), .i_m_rx_data_valid(m_rxv), .i_m_rx_data_byte(m_rxb)
  );

  int vectors = 0, errs = 0, issues = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    errs++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: FIFO contents as queues, one outstanding byte tracked by its age
  // in cycles since the issue edge (age 0 is the cycle valid is high).
  logic [10:0] mtx[$], mrx[$];
  bit          out = 0, mval = 0, movf = 0, mudf = 0, mtmo = 0;
  int          age = 0;
  logic [2:0]  cur_s = 3'd0;
  logic [7:0]  cur_b = 8'd0;

  task automatic model_step();
    bit txpop, txpush, rxpush, rxpop, tev;
    if (rst) begin
      mtx.delete(); mrx.delete();
      out = 0; age = 0; mval = 0; movf = 0; mudf = 0; mtmo = 0;
      cur_s = 3'd0; cur_b = 8'd0;
      return;
    end
    txpop  = !out && mtx.size() > 0 && mrx.size() < DEPTH && m_ready;
    rxpush = out && age >= 1 && m_rxv;
    tev    = out && age == TMO && !m_rxv;
    rxpop  = rx_pop && mrx.size() > 0;
    txpush = tx_push && mtx.size() < DEPTH;
    movf = (movf && !clr) || (tx_push && mtx.size() == DEPTH);
    mudf = (mudf && !clr) || (rx_pop && mrx.size() == 0);
    mtmo = (mtmo && !clr) || tev;
    mval = txpop;
    if (rxpop) void'(mrx.pop_front());
    if (rxpush) mrx.push_back({cur_s, m_rxb});
    if (txpop) begin
      {cur_s, cur_b} = mtx.pop_front();
      out = 1; age = 0;
    end else if (out) begin
      if (rxpush || tev) out = 0;
      else age++;
    end
    if (txpush) mtx.push_back({tx_slave, tx_byte});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("tx_level", 32'(tx_level), 32'(mtx.size()));
    chk("tx_full", 32'(tx_full), 32'(mtx.size() == DEPTH));
    chk("rx_empty", 32'(rx_empty), 32'(mrx.size() == 0));
    if (mrx.size() > 0) chk("rx_head", {21'd0, rx_slave, rx_byte}, {21'd0, mrx[0]});
    chk("busy", 32'(busy), 32'(out || mtx.size() > 0));
    chk("m_valid", 32'(m_valid), 32'(mval));
    chk("m_sel_byte", {21'd0, m_slave, m_byte}, {21'd0, cur_s, cur_b});
    chk("flags", {29'd0, ovf, udf, tmo_err}, {29'd0, movf, mudf, mtmo});
    if (m_valid) issues++;
  end

  // spi_master stand-in: drops ready on an issue, echoes the byte after lat cycles.
  bit         ready_en = 1, respond = 1;
  int         lat = 10;
  logic [7:0] mm_b;
  initial begin
    m_ready = 1'b0; m_rxv = 1'b0; m_rxb = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (m_valid && !rst) begin
        mm_b = m_byte;
        m_ready = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        if (respond) begin
          m_rxv = 1'b1; m_rxb = mm_b;
          @(posedge clk);
          #1;
          m_rxv = 1'b0;
        end
        m_ready = ready_en;
      end
    end
  end

  // All directed tasks start and end at a falling edge.
  task automatic push(input logic [2:0] s, input logic [7:0] b);
    tx_push = 1'b1; tx_slave = s; tx_byte = b;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int budget);
    int n = 0;
    while (rx_empty && n < budget) begin @(negedge clk); n++; end
    if (rx_empty) bound_fail(name);
  endtask

  task automatic pop_chk(input string name, input logic [2:0] s, input logic [7:0] b);
    wait_rx(name, 200);
    chk(name, {21'd0, rx_slave, rx_byte}, {21'd0, s, b});
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) bound_fail(name);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin @(negedge clk); n++; end
    if (!m_valid) bound_fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base, n, found;
  logic [7:0] lb[4] = '{8'h14, 8'h25, 8'h8E, 8'h23};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_level", 32'(tx_level), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, ovf, udf, tmo_err}, 0);
    m_ready = 1'b1;
    @(negedge clk);

    // Loopback: four bytes, echoed in order.
    base = issues;
    for (int i = 0; i < 4; i++) push(3'(i), lb[i]);
    wait_idle("lb_idle", 400);
    chk("lb_issues", 32'(issues - base), 4);
    for (int i = 0; i < 4; i++) pop_chk("lb_pop", 3'(i), lb[i]);
    chk("lb_flags", {29'd0, ovf, udf, tmo_err}, 0);

    // TX overflow with the master never ready.
    ready_en = 0; m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) chk("ovf_not_full_at3", 32'(tx_full), 0);
      push(3'd1, 8'(i));
    end
    chk("ovf_full_at4", 32'(tx_full), 1);
    push(3'd1, 8'h05);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_level", 32'(tx_level), 4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);
    ready_en = 1; m_ready = 1'b1;
    wait_idle("ovf_drain", 400);
    for (int i = 1; i <= 4; i++) pop_chk("ovf_pop", 3'd1, 8'(i));

    // RX backpressure: six bytes, no pops.
    base = issues;
    for (int i = 0; i < 4; i++) push(3'(i), 8'h30 + 8'(i));
    n = 0;
    while (tx_level > 2 && n < 200) begin @(negedge clk); n++; end
    if (tx_level > 2) bound_fail("bp_level");
    for (int i = 4; i < 6; i++) push(3'(i), 8'h30 + 8'(i));
    repeat (150) @(negedge clk);
    chk("bp_issues", 32'(issues - base), 4);
    chk("bp_valid_low", 32'(m_valid), 0);
    chk("bp_level", 32'(tx_level), 2);
    pop_chk("bp_pop", 3'd0, 8'h30);
    found = 0;
    for (int k = 0; k < 2 && !found; k++) begin
      if (m_valid) found = 1;
      else @(negedge clk);
    end
    if (m_valid) found = 1;
    chk("bp_issue_within_2", 32'(found), 1);
    for (int i = 1; i < 6; i++) pop_chk("bp_drain", 3'(i), 8'h30 + 8'(i));
    wait_idle("bp_idle", 200);

    // Timeout: master never answers.
    respond = 0; m_ready = 1'b0;
    push(3'd5, 8'hA5);
    m_ready = 1'b1;
    wait_valid("tmo_issue", 10);
    @(negedge clk);
    chk("tmo_valid_one_cycle", 32'(m_valid), 0);
    n = 0;
    while (!tmo_err && n < 40) begin @(negedge clk); n++; end
    chk("tmo_cycles_after_issue", 32'(n), 16);
    chk("tmo_rx_empty", 32'(rx_empty), 1);
    chk("tmo_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("tmo_cleared", 32'(tmo_err), 0);
    respond = 1;
    push(3'd5, 8'h5A);
    wait_idle("tmo_retry", 200);
    pop_chk("tmo_retry_pop", 3'd5, 8'h5A);

    // Underflow, then reset in the middle of WAIT_RX.
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    chk("udf_flag", 32'(udf), 1);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(3'd2, 8'h71 + 8'(i));
    m_ready = 1'b1;
    wait_valid("rst_issue", 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_level", 32'(tx_level), 0);
    chk("mid_rst_rx_empty", 32'(rx_empty), 1);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_flags", {29'd0, ovf, udf, tmo_err}, 0);
    repeat (20) @(negedge clk);
    chk("late_rxv_ignored", 32'(rx_empty), 1);
    chk("late_busy", 32'(busy), 0);

    // Simultaneous TX push and pop at level 2.
    ready_en = 0; m_ready = 1'b0;
    push(3'd1, 8'h81);
    push(3'd2, 8'h82);
    chk("sim_level_pre", 32'(tx_level), 2);
    m_ready = 1'b1;
    push(3'd3, 8'h83);
    m_ready = 1'b0;
    chk("sim_level_post", 32'(tx_level), 2);
    ready_en = 1; m_ready = 1'b1;
    wait_idle("sim_idle", 400);
    pop_chk("sim_pop0", 3'd1, 8'h81);
    pop_chk("sim_pop1", 3'd2, 8'h82);
    pop_chk("sim_pop2", 3'd3, 8'h83);
    chk("sim_end_empty", 32'(rx_empty), 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
